// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage feeding the main decoder. Holds the
//                PC, issues single-outstanding requests to instruction
//                memory, buffers responses in an output register plus a
//                one-entry skid buffer, and presents {instr, pc, op} to
//                decode with a valid/ready handshake. A redirect from
//                branch/JAL/JALR resolution flushes the stage.
//
//  Ports
//    clk, rst_n        rising-edge clock, asynchronous active-low reset
//    imem_req_*        fetch request (valid/ready, word-aligned address)
//    imem_rsp_*        fetch response (valid, 32-bit instruction)
//    redirect_*        one-cycle redirect strobe and target PC
//    id_valid/ready    handshake towards decode
//    id_instr/op/pc    instruction, its opcode field, and its PC
//    id_pc_plus4       link value for JAL/JALR
//
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_op,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    localparam logic [1:0]      S_IDLE       = 2'd0;
    localparam logic [1:0]      S_REQ        = 2'd1;
    localparam logic [1:0]      S_WAIT       = 2'd2;
    localparam logic [31:0]     C_NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] C_FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_drop;
    logic            w_drop_next;

    logic            r_out_valid;
    logic [31:0]     r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_skid_valid;
    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;

    logic            w_hs;
    logic            w_rsp;
    logic            w_keep;
    logic            w_free;
    logic            w_skid_next;
    logic            w_stale;

    // Handshake and response qualification
    assign w_hs   = (r_state == S_REQ) && imem_req_ready;
    assign w_rsp  = (r_state == S_WAIT) && imem_rsp_valid;
    assign w_keep = w_rsp && !r_drop && !redirect_valid;
    assign w_free = !r_out_valid || id_ready;

    // Skid occupancy after this edge: a redirect empties it; a freed output
    // slot drains it, after which a kept response lands in the slot if the
    // skid was empty or in the skid otherwise.
    always_comb begin
        w_skid_next = 1'b0;
        if (!redirect_valid) begin
            if (w_free) begin
                w_skid_next = r_skid_valid && w_keep;
            end else begin
                w_skid_next = r_skid_valid || w_keep;
            end
        end
    end

    // A redirect that arrives while a request is still waiting for ready
    // leaves that request at its old address; r_req_pc holds the address
    // and r_drop marks the request as stale.
    assign w_stale        = (r_state == S_REQ) && r_drop;
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = w_stale ? r_req_pc : r_pc;

    assign id_valid    = r_out_valid;
    assign id_instr    = r_out_instr;
    assign id_op       = r_out_instr[6:0];
    assign id_pc       = r_out_pc;
    assign id_pc_plus4 = r_out_pc + C_FOUR;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and drop flag
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            S_IDLE: begin
                if (!w_skid_next) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (w_hs) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_next = w_skid_next ? S_IDLE : S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (redirect_valid) begin
            // Drop is armed only while a response is still owed; one that
            // returns in the redirect cycle is consumed here.
            if (r_state == S_WAIT) begin
                w_drop_next = !imem_rsp_valid;
            end else if (r_state == S_REQ) begin
                w_drop_next = 1'b1;
            end
        end else if (w_rsp) begin
            w_drop_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PC and request address bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            // Capture the address of a live request when it is accepted,
            // or when a redirect turns it stale before acceptance.
            if ((r_state == S_REQ) && !r_drop && (w_hs || redirect_valid)) begin
                r_req_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc & C_ALIGN_MASK;
            end else if (w_hs && !r_drop) begin
                r_pc <= r_pc + C_FOUR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register and skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= C_NOP;
            r_out_pc     <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_skid_instr <= C_NOP;
            r_skid_pc    <= RESET_PC;
        end else begin
            r_skid_valid <= w_skid_next;
            if (redirect_valid) begin
                r_out_valid <= 1'b0;
            end else if (w_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= r_skid_instr;
                    r_out_pc    <= r_skid_pc;
                    if (w_keep) begin
                        r_skid_instr <= imem_rsp_data;
                        r_skid_pc    <= r_req_pc;
                    end
                end else if (w_keep) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= imem_rsp_data;
                    r_out_pc    <= r_req_pc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_keep) begin
                r_skid_instr <= imem_rsp_data;
                r_skid_pc    <= r_req_pc;
            end
        end
    end

endmodule
`default_nettype wire
